// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: 8-bit instruction word layout,
// the LOADI opcode and the session FSM states.
package program_loader_pkg;

    localparam int unsigned INSTR_W  = 8;
    localparam int unsigned OPC_MSB  = 7;
    localparam int unsigned OPC_LSB  = 4;
    localparam int unsigned REGA_MSB = 3;
    localparam int unsigned REGA_LSB = 2;
    localparam int unsigned FLD_MSB  = 1;
    localparam int unsigned FLD_LSB  = 0;

    localparam logic [3:0] LOADI = 4'b0001;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [INSTR_W-1:0] encode_instr(
        input logic [3:0] opcode,
        input logic [1:0] reg_a,
        input logic [1:0] field
    );
        logic [INSTR_W-1:0] word;
        word                   = '0;
        word[OPC_MSB:OPC_LSB]   = opcode;
        word[REGA_MSB:REGA_LSB] = reg_a;
        word[FLD_MSB:FLD_LSB]   = field;
        return word;
    endfunction

endpackage

// File: rtl/program_loader_fifo.sv
// Synchronous FIFO for encoded instruction words; a write and a read in the
// same cycle are allowed even when full, leaving the occupancy unchanged.
module loader_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en_i) rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({wr_en_i, rd_en_i})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign full_o    = (count_q == FULL_CNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;

endmodule

// File: rtl/program_loader.sv
// Packs decoded instruction fields into 8-bit words, buffers them and writes
// them to consecutive program-memory addresses during a load session.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_opcode,
    input  logic [1:0]         in_reg_a,
    input  logic [1:0]         in_reg_b,
    input  logic [3:0]         in_imm,
    input  logic               in_is_immediate,
    input  logic               in_last,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic               mem_ready,
    output logic               busy,
    output logic               done,
    output logic               full,
    output logic               err_imm,
    output logic               err_mode,
    output logic [ADDR_W:0]    word_count
);

    localparam int unsigned     CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [ADDR_W:0] CAP_V  = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CAP_M1 = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [ADDR_W:0] ONE_V  = {{ADDR_W{1'b0}}, 1'b1};

    state_t          state_q;
    logic [ADDR_W:0] acc_cnt_q;
    logic [ADDR_W:0] wr_cnt_q;
    logic            closed_q;
    logic            err_imm_q;
    logic            err_mode_q;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [INSTR_W-1:0] fifo_head;
    logic [INSTR_W-1:0] enc_word;

    logic ready_int;
    logic accept;
    logic bad_imm;
    logic bad_mode;
    logic enq;
    logic deq;
    logic closed_d;
    logic drained_d;

    always_comb begin
        ready_int = (state_q == S_LOAD) && !fifo_full && !closed_q && (acc_cnt_q != CAP_V);
        accept    = in_valid && ready_int;
        bad_imm   = in_is_immediate && (in_imm[3:2] != 2'b00);
        bad_mode  = in_is_immediate && (in_opcode != LOADI);
        enq       = accept && !bad_imm && !bad_mode;
        deq       = !fifo_empty && mem_ready;
        enc_word  = encode_instr(in_opcode, in_reg_a,
                                 in_is_immediate ? in_imm[1:0] : in_reg_b);
        closed_d  = closed_q || (accept && in_last) || (enq && acc_cnt_q == CAP_M1);
        // Look at next-cycle occupancy so done rises right after the final write.
        drained_d = (fifo_count == CNT_W'(0) && !enq) ||
                    (fifo_count == CNT_W'(1) && deq && !enq);
    end

    loader_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (enq),
        .wr_data_i (enc_word),
        .rd_en_i   (deq),
        .rd_data_o (fifo_head),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (fifo_count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            acc_cnt_q  <= '0;
            wr_cnt_q   <= '0;
            closed_q   <= 1'b0;
            err_imm_q  <= 1'b0;
            err_mode_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        acc_cnt_q  <= '0;
                        wr_cnt_q   <= '0;
                        closed_q   <= 1'b0;
                        err_imm_q  <= 1'b0;
                        err_mode_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept && bad_imm)  err_imm_q  <= 1'b1;
                    if (accept && bad_mode) err_mode_q <= 1'b1;
                    if (enq) acc_cnt_q <= acc_cnt_q + ONE_V;
                    if (deq) wr_cnt_q  <= wr_cnt_q + ONE_V;
                    closed_q <= closed_d;
                    if (closed_d && drained_d) state_q <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = ready_int;
    assign mem_we     = !fifo_empty;
    assign mem_wdata  = fifo_empty ? '0 : fifo_head;
    assign mem_addr   = wr_cnt_q[ADDR_W-1:0];
    assign word_count = wr_cnt_q;
    assign busy       = (state_q == S_LOAD);
    assign done       = (state_q == S_DONE);
    assign full       = (acc_cnt_q == CAP_V);
    assign err_imm    = err_imm_q;
    assign err_mode   = err_mode_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: randomized bundles and memory
// back-pressure compared against a queue-based model of the expected writes.
module tb_program_loader;

    localparam int ADDR_W     = 4;
    localparam int FIFO_DEPTH = 2;
    localparam int CAP        = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_opcode;
    logic [1:0]        in_reg_a;
    logic [1:0]        in_reg_b;
    logic [3:0]        in_imm;
    logic              in_is_immediate;
    logic              in_last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready;
    logic              busy;
    logic              done;
    logic              full;
    logic              err_imm;
    logic              err_mode;
    logic [ADDR_W:0]   word_count;

    always #5 clk = ~clk;

    program_loader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_opcode       (in_opcode),
        .in_reg_a        (in_reg_a),
        .in_reg_b        (in_reg_b),
        .in_imm          (in_imm),
        .in_is_immediate (in_is_immediate),
        .in_last         (in_last),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_ready       (mem_ready),
        .busy            (busy),
        .done            (done),
        .full            (full),
        .err_imm         (err_imm),
        .err_mode        (err_mode),
        .word_count      (word_count)
    );

    int checks = 0;
    int errors = 0;
    int timeouts = 0;
    int ready_mode = 0;          // 0 always ready, 1 toggle, 2 random, 3 never
    int got_addr[$];
    int got_data[$];
    int exp_data[$];
    bit exp_err_imm;
    bit exp_err_mode;
    int stall_viol = 0;
    bit prev_stall = 0;
    logic [ADDR_W-1:0] prev_addr;
    logic [7:0]        prev_data;
    int last_wait = 0;
    int saw_ready_low = 0;
    int done_wait = 0;

    // One clock cycle: record completed writes and stall stability, then advance.
    task automatic tick();
        if (prev_stall && (mem_we !== 1'b1 || mem_addr !== prev_addr || mem_wdata !== prev_data))
            stall_viol++;
        if (mem_we === 1'b1 && mem_ready === 1'b1) begin
            got_addr.push_back(int'(mem_addr));
            got_data.push_back(int'(mem_wdata));
        end
        prev_stall = (mem_we === 1'b1) && (mem_ready !== 1'b1);
        prev_addr  = mem_addr;
        prev_data  = mem_wdata;
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = ~mem_ready;
            2:       mem_ready = 1'($urandom_range(0, 1));
            default: mem_ready = 1'b0;
        endcase
    endtask

    task automatic set_mode(input int m);
        ready_mode = m;
        mem_ready  = (m == 0 || m == 1);
    endtask

    task automatic clear_model();
        exp_data.delete();
        got_addr.delete();
        got_data.delete();
        exp_err_imm  = 0;
        exp_err_mode = 0;
        stall_viol   = 0;
        prev_stall   = 0;
    endtask

    // Reference: a bundle is kept unless it carries a bad immediate or an
    // immediate on a non-LOADI opcode; kept words land at consecutive addresses.
    task automatic model(input int op, ra, rb, imm, input bit isimm);
        bit rej_i;
        bit rej_m;
        rej_i = isimm && (imm > 3);
        rej_m = isimm && (op != 1);
        if (rej_i) exp_err_imm = 1;
        if (rej_m) exp_err_mode = 1;
        if (!rej_i && !rej_m)
            exp_data.push_back(op * 16 + ra * 4 + (isimm ? imm : rb));
    endtask

    task automatic send(input int op, ra, rb, imm, input bit isimm, last);
        int waits;
        waits = 0;
        in_valid        = 1'b1;
        in_opcode       = 4'(op);
        in_reg_a        = 2'(ra);
        in_reg_b        = 2'(rb);
        in_imm          = 4'(imm);
        in_is_immediate = isimm;
        in_last         = last;
        while (in_ready !== 1'b1 && waits < 200) begin
            saw_ready_low++;
            tick();
            waits++;
        end
        if (waits >= 200) begin
            timeouts++;
            in_valid = 1'b0;
            in_last  = 1'b0;
            return;
        end
        last_wait = waits;
        model(op, ra, rb, imm, isimm);
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        prev_stall = 0;
    endtask

    task automatic wait_done();
        done_wait = 0;
        while (done !== 1'b1 && done_wait < 400) begin
            tick();
            done_wait++;
        end
        if (done !== 1'b1) timeouts++;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_opcode = '0; in_reg_a = '0;
        in_reg_b = '0; in_imm = '0; in_is_immediate = 1'b0; in_last = 1'b0;
        mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, mem_we, busy, done, full, err_imm, err_mode} !== 7'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 0000000",
                     {in_ready, mem_we, busy, done, full, err_imm, err_mode});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
            errors++;
            $display("FAIL reset_values: addr=%0h wdata=%0h count=%0d, expected all 0",
                     mem_addr, mem_wdata, word_count);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: in_ready=%b busy=%b, expected 0 0", in_ready, busy);
        end
    endtask

    task automatic test_basic();
        clear_model();
        set_mode(0);
        pulse_start();
        send(1, 2, 0, 3, 1, 0);
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 8'h1B || mem_addr !== 4'd0) begin
            errors++;
            $display("FAIL basic_latency: we=%b data=%0h addr=%0d, expected 1 1b 0",
                     mem_we, mem_wdata, mem_addr);
        end
        send(2, 1, 3, 0, 0, 1);
        wait_done();
        checks++;
        if (done_wait !== 1) begin
            errors++;
            $display("FAIL basic_done_timing: done after %0d cycles, expected 1", done_wait);
        end
        checks++;
        if (got_data.size() != 2) begin
            errors++;
            $display("FAIL basic_count: got %0d writes, expected 2", got_data.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (got_addr[i] !== i || got_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL basic_write[%0d]: got %0h@%0d, expected %0h@%0d",
                             i, got_data[i], got_addr[i], exp_data[i], i);
                end
            end
        end
        checks++;
        if (word_count !== 5'd2 || done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_final: count=%0d done=%b busy=%b, expected 2 1 0",
                     word_count, done, busy);
        end
    endtask

    task automatic test_err_imm();
        clear_model();
        set_mode(0);
        pulse_start();
        send(1, 0, 0, 5, 1, 0);
        checks++;
        if (err_imm !== 1'b1 || err_mode !== 1'b0 || mem_we !== 1'b0) begin
            errors++;
            $display("FAIL err_imm_flag: err_imm=%b err_mode=%b we=%b, expected 1 0 0",
                     err_imm, err_mode, mem_we);
        end
        send(2, 3, 1, 0, 0, 1);
        wait_done();
        checks++;
        if (got_data.size() != 1 || got_addr[0] !== 0 || got_data[0] !== exp_data[0]) begin
            errors++;
            $display("FAIL err_imm_write: got %0d writes first %0h@%0d, expected %0h@0",
                     got_data.size(), got_data.size() ? got_data[0] : -1,
                     got_addr.size() ? got_addr[0] : -1, exp_data[0]);
        end
        checks++;
        if (err_imm !== 1'b1) begin
            errors++;
            $display("FAIL err_imm_sticky: err_imm=%b, expected 1", err_imm);
        end
    endtask

    task automatic test_err_mode();
        clear_model();
        set_mode(0);
        pulse_start();
        send(2, 0, 0, 2, 1, 0);
        checks++;
        if (err_mode !== 1'b1 || err_imm !== 1'b0) begin
            errors++;
            $display("FAIL err_mode_flag: err_mode=%b err_imm=%b, expected 1 0", err_mode, err_imm);
        end
        send(1, 0, 1, 0, 0, 1);
        wait_done();
        checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h11 || got_addr[0] !== 0) begin
            errors++;
            $display("FAIL err_mode_write: got %0d writes first %0h, expected 1 write 11@0",
                     got_data.size(), got_data.size() ? got_data[0] : -1);
        end
        checks++;
        if (err_imm !== 1'b0 || err_mode !== 1'b1) begin
            errors++;
            $display("FAIL err_mode_final: err_imm=%b err_mode=%b, expected 0 1", err_imm, err_mode);
        end
    endtask

    task automatic test_random();
        clear_model();
        set_mode(2);
        pulse_start();
        for (int k = 0; k < 12; k++) begin
            int op;
            int imm;
            bit isimm;
            op    = $urandom_range(0, 15);
            imm   = $urandom_range(0, 15);
            isimm = 1'($urandom_range(0, 1));
            if (isimm && $urandom_range(0, 1) == 1) op = 1;
            if (isimm && $urandom_range(0, 1) == 1) imm = imm % 4;
            send(op, $urandom_range(0, 3), $urandom_range(0, 3), imm, isimm, k == 11);
        end
        wait_done();
        checks++;
        if (got_data.size() != exp_data.size()) begin
            errors++;
            $display("FAIL random_count: got %0d writes, expected %0d", got_data.size(), exp_data.size());
        end else begin
            for (int i = 0; i < exp_data.size(); i++) begin
                checks++;
                if (got_addr[i] !== i || got_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL random_write[%0d]: got %0h@%0d, expected %0h@%0d",
                             i, got_data[i], got_addr[i], exp_data[i], i);
                end
            end
        end
        checks++;
        if (err_imm !== exp_err_imm || err_mode !== exp_err_mode ||
            int'(word_count) !== exp_data.size() || stall_viol !== 0) begin
            errors++;
            $display("FAIL random_final: err_imm=%b err_mode=%b count=%0d stalls=%0d, expected %b %b %0d 0",
                     err_imm, err_mode, word_count, stall_viol, exp_err_imm, exp_err_mode, exp_data.size());
        end
    endtask

    task automatic test_fill_stall();
        clear_model();
        set_mode(1);
        pulse_start();
        saw_ready_low = 0;
        for (int k = 0; k < CAP; k++)
            send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, 0);
        checks++;
        if (full !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b in_ready=%b, expected 1 0", full, in_ready);
        end
        checks++;
        if (saw_ready_low == 0) begin
            errors++;
            $display("FAIL fill_backpressure: in_ready low %0d cycles, expected >0", saw_ready_low);
        end
        wait_done();
        checks++;
        if (got_data.size() != CAP) begin
            errors++;
            $display("FAIL fill_count: got %0d writes, expected %0d", got_data.size(), CAP);
        end else begin
            for (int i = 0; i < CAP; i++) begin
                checks++;
                if (got_addr[i] !== i || got_data[i] !== exp_data[i]) begin
                    errors++;
                    $display("FAIL fill_write[%0d]: got %0h@%0d, expected %0h@%0d",
                             i, got_data[i], got_addr[i], exp_data[i], i);
                end
            end
        end
        checks++;
        if (stall_viol !== 0 || word_count !== 5'd16 || done !== 1'b1) begin
            errors++;
            $display("FAIL fill_final: stalls=%0d count=%0d done=%b, expected 0 16 1",
                     stall_viol, word_count, done);
        end
    endtask

    task automatic test_back_to_back();
        int max_wait;
        int t0;
        clear_model();
        set_mode(0);
        pulse_start();
        max_wait = 0;
        t0 = $time;
        for (int k = 0; k < 6; k++) begin
            send($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3), 0, 0, k == 5);
            if (last_wait > max_wait) max_wait = last_wait;
        end
        wait_done();
        checks++;
        if (max_wait !== 0 || ($time - t0) !== 70) begin
            errors++;
            $display("FAIL b2b_throughput: max wait %0d, elapsed %0t, expected 0 and 70",
                     max_wait, $time - t0);
        end
        checks++;
        if (got_data.size() != 6 || got_data !== exp_data) begin
            errors++;
            $display("FAIL b2b_data: got %0d writes, expected 6 matching model", got_data.size());
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        set_mode(3);
        pulse_start();
        send(3, 1, 2, 0, 0, 0);
        send(4, 2, 1, 0, 0, 0);
        checks++;
        if (mem_we !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_buffered: we=%b in_ready=%b, expected 1 0", mem_we, in_ready);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({in_ready, mem_we, busy, done, full, err_imm, err_mode} !== 7'b0 ||
            mem_addr !== '0 || mem_wdata !== '0 || word_count !== '0) begin
            errors++;
            $display("FAIL mid_reset_values: flags=%b addr=%0h wdata=%0h count=%0d, expected all 0",
                     {in_ready, mem_we, busy, done, full, err_imm, err_mode}, mem_addr, mem_wdata, word_count);
        end
        set_mode(0);
        tick();
        tick();
        rst = 1'b0;
        checks++;
        if (got_data.size() != 0) begin
            errors++;
            $display("FAIL mid_no_write: got %0d writes under reset, expected 0", got_data.size());
        end
        clear_model();
        pulse_start();
        send(5, 3, 3, 0, 0, 1);
        wait_done();
        checks++;
        if (got_data.size() != 1 || got_addr[0] !== 0 || got_data[0] !== exp_data[0]) begin
            errors++;
            $display("FAIL mid_restart_write: got %0d writes first addr %0d, expected 1 write at 0",
                     got_data.size(), got_addr.size() ? got_addr[0] : -1);
        end
    endtask

    task automatic test_restart();
        clear_model();
        set_mode(3);
        pulse_start();
        send(1, 1, 0, 9, 1, 0);
        send(6, 0, 2, 0, 0, 0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || err_imm !== 1'b1 || mem_we !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_in_load: busy=%b err_imm=%b we=%b done=%b, expected 1 1 1 0",
                     busy, err_imm, mem_we, done);
        end
        set_mode(0);
        send(7, 1, 1, 0, 0, 1);
        wait_done();
        checks++;
        if (got_data.size() != 2 || got_data !== exp_data || word_count !== 5'd2) begin
            errors++;
            $display("FAIL start_in_load_data: got %0d writes count=%0d, expected 2 2",
                     got_data.size(), word_count);
        end
        clear_model();
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err_imm !== 1'b0 || word_count !== '0 || full !== 1'b0) begin
            errors++;
            $display("FAIL start_in_done: done=%b busy=%b err_imm=%b count=%0d full=%b, expected 0 1 0 0 0",
                     done, busy, err_imm, word_count, full);
        end
        send(1, 3, 0, 2, 1, 1);
        wait_done();
        checks++;
        if (got_data.size() != 1 || got_addr[0] !== 0 || got_data[0] !== 8'h1E) begin
            errors++;
            $display("FAIL restart_write: got %0d writes first %0h, expected 1e@0",
                     got_data.size(), got_data.size() ? got_data[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_err_imm();
        test_err_mode();
        test_random();
        test_fill_stall();
        test_back_to_back();
        test_reset_mid();
        test_restart();
        checks++;
        if (timeouts !== 0) begin
            errors++;
            $display("FAIL handshake_timeouts: got %0d expired waits, expected 0", timeouts);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_loader.md
# program_loader

Sequential instruction encoder and program-memory writer: accepts decoded instruction fields over a valid/ready stream, packs each into the 8-bit instruction word format that the processor's decoder consumes, buffers them in a small FIFO, and writes them to consecutive program-memory addresses through a write handshake. It sits between the testbench/host or boot source and the instruction memory, ahead of the fetch/decode path.

## Interface
- ADDR_W, 4, program-memory address width; capacity CAP = 2^ADDR_W words
- FIFO_DEPTH, 2, encoded-word buffer depth (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins a load session
- in_valid  in  1  field bundle valid
- in_ready  out  1  loader accepts bundle this cycle
- in_opcode  in  4  opcode
- in_reg_a  in  2  destination/first register
- in_reg_b  in  2  second register (used when in_is_immediate=0)
- in_imm  in  4  immediate (used when in_is_immediate=1)
- in_is_immediate  in  1  bundle carries an immediate
- in_last  in  1  final instruction of program
- mem_we  out  1  write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  8  encoded instruction
- mem_ready  in  1  memory accepts write this cycle
- busy  out  1  session active (state LOAD)
- done  out  1  session complete, all words written
- full  out  1  CAP words accepted
- err_imm  out  1  sticky: immediate > 3 rejected
- err_mode  out  1  sticky: immediate on non-LOADI opcode rejected
- word_count  out  ADDR_W+1  words written to memory

## Operation
- Encoding: word = {opcode, reg_a, field}; field = in_imm[1:0] if in_is_immediate else in_reg_b. LOADI = 4'b0001.
- Validation at acceptance: in_is_immediate=1 and in_imm[3:2]≠0 → bundle consumed, not enqueued, err_imm set. in_is_immediate=1 and opcode≠LOADI → consumed, not enqueued, err_mode set. Both true → both flags set. Rejected bundles do not count toward CAP; in_last on a rejected bundle still ends input.
- Opcode LOADI with in_is_immediate=0 is encoded from in_reg_b unchanged, no error.
- States: IDLE, LOAD, DONE.
  - IDLE: in_ready=0, mem_we=0. start → LOAD, clear acc_cnt, word_count, write address, errors, input-closed flag.
  - LOAD: in_ready = !fifo_full && !closed && acc_cnt<CAP. Handshake in_valid&&in_ready accepts. Accepting in_last or reaching acc_cnt==CAP sets closed. closed && FIFO empty && !mem_we → DONE.
  - DONE: done=1, outputs held. start → LOAD (same clearing as IDLE). start in LOAD ignored.
- Write side: FIFO head drives mem_wdata; mem_addr starts at 0, increments by 1 per completed write (mem_we&&mem_ready); word_count increments with it. Address never wraps: at most CAP writes per session.
- full = acc_cnt==CAP, cleared by start.
- Simultaneous enqueue and dequeue on a full FIFO permitted (occupancy unchanged).

## Timing
- Reset: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, full=0, err_imm=0, err_mode=0, word_count=0, FIFO empty. Reset mid-session discards all buffered words; no write completes after reset asserts.
- in_ready is a registered-state function; no combinational path from in_valid to in_ready.
- Latency: bundle accepted in cycle N → mem_we=1 with its word in cycle N+1 earliest.
- mem_we, mem_addr, mem_wdata stable while mem_we=1 && mem_ready=0; mem_we never drops without mem_ready.
- Back-to-back: with mem_ready held high, one word per cycle sustained.
- done rises the cycle after the final write completes; err flags rise the cycle after the offending acceptance.

## Structure
- Shared package: LOADI opcode constant, field bit-position constants (opcode [7:4], reg_a [3:2], field [1:0]), instruction-word width 8, state enum.
- One sub-module: loader_fifo (synchronous FIFO, parameterised width/depth, full/empty outputs).

## Test plan
- start; send LOADI r2,#3 then opcode 0010 r1,r3 with last, mem_ready=1 → writes 0x1B@0, 0x27@1, word_count=2, done=1.
- LOADI r0,#5 → rejected, err_imm=1, no write; following valid bundle written at address 0.
- Opcode 0010 with in_is_immediate=1, imm=2 → rejected, err_mode=1; LOADI with is_immediate=0, reg_b=1 → 0x11 written, no error.
- Stream 16 words without last, mem_ready toggling 1/0 → in_ready low once FIFO full, data/addr stable during stalls, full=1 after 16th accept, addresses 0–15 then done.
- Assert rst mid-session with 2 words buffered → all outputs at reset values, next start writes from address 0.
- start during LOAD → ignored; start in DONE → done clears, counters and errors cleared, new session from address 0.
